csa_accumulator: RTL

//   Streaming multi-operand accumulator built on carry-save compression. Each accepted operand is folded

---
 rtl/csa_acc_pkg.sv | 23 ++
 rtl/csa_cpa_slice.sv | 23 ++
 rtl/csa_accumulator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  function automatic int calc_w(input int n, input int cnt_w);
    return n + cnt_w;
  endfunction

  // Rounded up so a non-dividing CPA_W is caught by slices_exact rather than silently truncated.
  function automatic int calc_r(input int w, input int cpa_w);
    return (w + cpa_w - 1) / cpa_w;
  endfunction

  function automatic bit slices_exact(input int w, input int cpa_w);
    return (calc_r(w, cpa_w) * cpa_w) == w;
  endfunction

endpackage

// File: rtl/csa_cpa_slice.sv
// CPA_W-bit ripple-carry adder slice; purely combinational, no flow control.
module csa_cpa_slice #(
  parameter int CPA_W = 8
) (
  input  logic [CPA_W-1:0] a_i,
  input  logic [CPA_W-1:0] b_i,
  input  logic             cin_i,
  output logic [CPA_W-1:0] sum_o,
  output logic             cout_o
);

  logic [CPA_W:0] cy;

  assign cy[0] = cin_i;

  for (genvar i = 0; i < CPA_W; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ cy[i];
    assign cy[i+1]  = (a_i[i] & b_i[i]) | (a_i[i] & cy[i]) | (b_i[i] & cy[i]);
  end

  assign cout_o = cy[CPA_W];

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save packet accumulator: 1 beat/cycle, result R=W/CPA_W cycles after last beat, held until out_ready.
// in_ready low outside ACCUM; define CSA_ACC_SAT_EN to saturate out_sum on overflow.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int N      = 32,
  parameter int CNT_W  = 8,
  parameter int CPA_W  = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_of,
  output logic [CNT_W-1:0] out_count
);

  localparam int W   = calc_w(N, CNT_W);
  localparam int R   = calc_r(W, CPA_W);
  localparam int K_W = (R > 1) ? $clog2(R) : 1;

  if (!slices_exact(W, CPA_W)) begin : g_bad_cpa_w
    $error("csa_accumulator: CPA_W must divide N+CNT_W");
  end

  state_e           state_q, state_d;
  logic [W-1:0]     s_q, c_q, t_q;
  logic [W-1:0]     ext_d, fa_s;
  logic [W-2:0]     fa_c;
  logic [CNT_W-1:0] count_q;
  logic             sticky_q;
  logic [K_W-1:0]   k_q;
  logic             cy_q;
  logic [CPA_W-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic [W-N:0]     t_top;
  logic             of_arith;

  assign in_ready  = rst_n && (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign accept    = in_valid && in_ready;

  assign ext_d = (SIGNED != 0) ? {{CNT_W{in_data[N-1]}}, in_data} : {{CNT_W{1'b0}}, in_data};

  // c_q holds the carry vector already shifted left, so S + C is the running total.
  for (genvar i = 0; i < W; i++) begin : g_csa
    assign fa_s[i] = s_q[i] ^ c_q[i] ^ ext_d[i];
    if (i < W - 1) begin : g_cy
      assign fa_c[i] = (s_q[i] & c_q[i]) | (s_q[i] & ext_d[i]) | (c_q[i] & ext_d[i]);
    end
  end

  csa_cpa_slice #(.CPA_W(CPA_W)) u_slice (
    .a_i   (s_q[CPA_W-1:0]),
    .b_i   (c_q[CPA_W-1:0]),
    .cin_i (cy_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last)            state_d = RESOLVE;
      RESOLVE: if (k_q == K_W'(R - 1))           state_d = OUTPUT;
      OUTPUT:  if (out_ready)                    state_d = ACCUM;
      default:                                   state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= '0;
      c_q      <= '0;
      t_q      <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      k_q      <= '0;
      cy_q     <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: if (accept) begin
          s_q  <= fa_s;
          c_q  <= {fa_c, 1'b0};
          k_q  <= '0;
          cy_q <= 1'b0;
          if (count_q == '1) sticky_q <= 1'b1;
          else               count_q  <= count_q + 1'b1;
        end
        // S and C shift down so the slice adder always sees the next unresolved bits.
        RESOLVE: begin
          s_q <= s_q >> CPA_W;
          c_q <= c_q >> CPA_W;
          cy_q <= slice_cout;
          t_q[k_q*CPA_W +: CPA_W] <= slice_sum;
          k_q <= k_q + 1'b1;
        end
        OUTPUT: if (out_ready) begin
          s_q      <= '0;
          c_q      <= '0;
          count_q  <= '0;
          sticky_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign t_top    = t_q[W-1:N-1];
  assign of_arith = (SIGNED != 0) ? !((&t_top) || !(|t_top)) : (|t_q[W-1:N]);
  assign out_of    = of_arith | sticky_q;
  assign out_count = count_q;

`ifdef CSA_ACC_SAT_EN
  always_comb begin
    out_sum = t_q[N-1:0];
    if (out_of) begin
      if (SIGNED != 0) out_sum = t_q[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else             out_sum = '1;
    end
  end
`else
  assign out_sum = t_q[N-1:0];
`endif

endmodule
